wifi_tx_cp_framer: RTL and testbench
====================================

WIFI_TX_CP_FRAMER -- requirements
Module: wifi_tx_cp_framer

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 12, meaning the width of each real and imaginary sample.
REQ-002 SHALL have parameter NFFT, default 64, meaning the number of samples per OFDM symbol; it is a power of 2.
REQ-003 SHALL have parameter CP_LONG, default 16, meaning the long guard-interval length; 1 <= CP_LONG <= NFFT.
REQ-004 SHALL have parameter CP_SHORT, default 8, meaning the short guard-interval length; 1 <= CP_SHORT <= CP_LONG.
REQ-005 SHALL have ports in this order:
- clk_ifft  in  1  clock.
- reset  in  1  reset; asynchronous, active-low.
- valid_in  in  1  input sample valid.
- ready_in  out  1  framer can accept an input sample.
- data_in_re  in  SAMPLE_W  IFFT output, real part.
- data_in_im  in  SAMPLE_W  IFFT output, imaginary part.
- last_sym_in  in  1  symbol is the frame's last; sampled on any accepted sample of the symbol (OR-ed).
- short_gi  in  1  1 selects CP_SHORT, 0 selects CP_LONG; sampled on sample 0 of each symbol.
- valid_out  out  1  output sample valid.
- ready_out  in  1  downstream accepts the output sample.
- data_out_re  out  SAMPLE_W  framed sample, real part.
- data_out_im  out  SAMPLE_W  framed sample, imaginary part.
- sym_start_out  out  1  marks the first CP sample of a symbol.
- last_out  out  1  marks the final sample of the frame's last symbol.
- sym_count  out  16  symbols fully emitted in the current frame.
- en_tx_irq  in  1  interrupt enable.
- clear_tx_irq  in  1  interrupt clear.
- tx_irq  out  1  sticky frame-done interrupt.
- frame_done  out  1  one-cycle pulse when the frame's last sample is accepted downstream.

Function
REQ-006 SHALL buffer samples in two NFFT-deep ping-pong banks; each bank holds a full flag, a last flag and a gi flag.
REQ-007 SHALL drive ready_in = NOT full[wr_bank]; a sample is accepted when valid_in AND ready_in, and is written at wr_idx.
REQ-008 SHALL, on accepting sample NFFT-1, set full[wr_bank], reset wr_idx to 0 and toggle wr_bank; the flags take effect the next cycle.
REQ-009 SHALL implement a read FSM with states IDLE, CP and BODY.
- IDLE: if full[rd_bank], go to CP with rd_idx = NFFT - cp_len.
- CP: issue samples through index NFFT-1, then go to BODY with rd_idx = 0.
- BODY: issue samples through index NFFT-1.
REQ-010 SHALL, on issuing BODY sample NFFT-1: clear full[rd_bank], toggle rd_bank, then go to CP if the other bank is full (no bubble), else to IDLE.
REQ-011 SHALL issue a sample only when the output register is empty or being accepted (NOT valid_out OR ready_out); the FSM stalls otherwise.
REQ-012 SHALL register data_out_re, data_out_im, sym_start_out and last_out together, held stable while valid_out AND NOT ready_out.
REQ-013 SHALL emit NFFT + cp_len samples per symbol: indices NFFT-cp_len .. NFFT-1, then 0 .. NFFT-1.
REQ-014 SHALL raise valid_out 2 cycles after acceptance of input sample NFFT-1 when the FSM is IDLE and the output is empty.
REQ-015 SHALL update sym_count as follows:
- increment it when the final sample of each symbol is accepted downstream (valid_out AND ready_out);
- clear it to 0 on the cycle frame_done pulses;
- let it wrap at 16 bits.
REQ-016 SHALL pulse frame_done when last_out is accepted downstream; tx_irq is set on frame_done if en_tx_irq is 1.
REQ-017 SHALL clear tx_irq on clear_tx_irq; if set and clear coincide, set wins.
REQ-018 SHALL, within a single cycle, allow a bank to complete on the write side while the other bank frees on the read side; a just-freed bank accepts writes from the next cycle.

Reset
REQ-019 SHALL, on reset low, asynchronously clear the following: all output registers, valid_out, sym_start_out, last_out, data_out_re, data_out_im, sym_count, tx_irq, frame_done, full/last/gi flags, wr_bank, rd_bank, wr_idx, rd_idx; the FSM returns to IDLE.
REQ-020 SHALL hold ready_in at 1 after reset; partial symbols in progress at reset are discarded.
REQ-021 SHALL leave bank data contents unreset.

Structure
REQ-022 SHALL place the FSM state encodings and the default SAMPLE_W, NFFT, CP_LONG and CP_SHORT values in the shared package wifi_tx_cp_pkg.
REQ-023 SHALL implement the two-bank memory as sub-module wifi_tx_cp_bank, with one write port, a combinational read port, and a bank select on each port.

Verification
REQ-024 SHALL verify single symbol, defaults, short_gi=0, last_sym_in=1, en_tx_irq=1, ready_out=1, samples re=k, im=-k -> 80 contiguous outputs re = 48..63 then 0..63, sym_start_out on the first, last_out on the 80th, then frame_done, tx_irq=1 and sym_count back to 0.
REQ-025 SHALL verify 3 symbols offered back-to-back with valid_in held high -> 240 contiguous outputs; ready_in drops while both banks are full; no sample is lost or duplicated.
REQ-026 SHALL verify short_gi=1 on symbol 2 only -> symbol 1 is 80 samples, symbol 2 is 72 samples starting at index 56.
REQ-027 SHALL verify ready_out toggling 1/0 pseudo-randomly -> the output sequence is identical to REQ-024, and data is held while stalled.
REQ-028 SHALL verify clear_tx_irq=1 in the same cycle as frame_done -> tx_irq=1; clear_tx_irq on a later cycle -> tx_irq=0. With en_tx_irq=0 -> tx_irq stays 0.
REQ-029 SHALL verify reset asserted after 30 input samples, then a fresh symbol -> no stale outputs, the first output is the fresh symbol's sample 48, and sym_count=0.

Source files
------------

// File: rtl/wifi_tx_cp_pkg.sv
// Shared defaults and read-FSM encoding for the Wi-Fi TX cyclic-prefix framer.
`timescale 1ns/1ps
package wifi_tx_cp_pkg;
   localparam int SAMPLE_W_DEF = 12;
   localparam int NFFT_DEF     = 64;
   localparam int CP_LONG_DEF  = 16;
   localparam int CP_SHORT_DEF = 8;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_CP   = 2'd1,
      RD_BODY = 2'd2
   } rd_state_e;
endpackage

// File: rtl/wifi_tx_cp_bank.sv
// Two NFFT-deep ping-pong sample banks: one synchronous write port, one combinational read port.
`timescale 1ns/1ps
module wifi_tx_cp_bank
   import wifi_tx_cp_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int NFFT     = NFFT_DEF,
   parameter int IDX_W    = (NFFT > 1) ? $clog2(NFFT) : 1
) (
   input  logic                clk_ifft,
   input  logic                we,
   input  logic                wr_sel,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [SAMPLE_W-1:0] wr_re,
   input  logic [SAMPLE_W-1:0] wr_im,
   input  logic                rd_sel,
   input  logic [IDX_W-1:0]    rd_idx,
   output logic [SAMPLE_W-1:0] rd_re,
   output logic [SAMPLE_W-1:0] rd_im
);
   logic [SAMPLE_W-1:0] mem_re [0:2*NFFT-1];
   logic [SAMPLE_W-1:0] mem_im [0:2*NFFT-1];

   always_ff @(posedge clk_ifft) begin
      if (we) begin
         mem_re[{wr_sel, wr_idx}] <= wr_re;
         mem_im[{wr_sel, wr_idx}] <= wr_im;
      end
   end

   assign rd_re = mem_re[{rd_sel, rd_idx}];
   assign rd_im = mem_im[{rd_sel, rd_idx}];
endmodule

// File: rtl/wifi_tx_cp_framer.sv
// Prepends a cyclic prefix to each IFFT symbol: writes into ping-pong banks,
// reads back the tail as CP followed by the full body through a registered output.
`timescale 1ns/1ps
module wifi_tx_cp_framer
   import wifi_tx_cp_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int NFFT     = NFFT_DEF,
   parameter int CP_LONG  = CP_LONG_DEF,
   parameter int CP_SHORT = CP_SHORT_DEF
) (
   input  logic                clk_ifft,
   input  logic                reset,
   input  logic                valid_in,
   output logic                ready_in,
   input  logic [SAMPLE_W-1:0] data_in_re,
   input  logic [SAMPLE_W-1:0] data_in_im,
   input  logic                last_sym_in,
   input  logic                short_gi,
   output logic                valid_out,
   input  logic                ready_out,
   output logic [SAMPLE_W-1:0] data_out_re,
   output logic [SAMPLE_W-1:0] data_out_im,
   output logic                sym_start_out,
   output logic                last_out,
   output logic [15:0]         sym_count,
   input  logic                en_tx_irq,
   input  logic                clear_tx_irq,
   output logic                tx_irq,
   output logic                frame_done
);
   localparam int IDX_W = (NFFT > 1) ? $clog2(NFFT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NFFT - 1);
   localparam logic [IDX_W-1:0] CPL_START = IDX_W'(NFFT - CP_LONG);
   localparam logic [IDX_W-1:0] CPS_START = IDX_W'(NFFT - CP_SHORT);

   logic [1:0]          full, last_f, gi_f;
   logic                wr_bank, rd_bank;
   logic [IDX_W-1:0]    wr_idx, rd_idx, rd_idx_nxt;
   rd_state_e           state, state_nxt;
   logic                acc, wr_done, issue, body_end, out_acc, sym_end_q;
   logic [IDX_W-1:0]    cp_start_cur, cp_start_oth;
   logic [SAMPLE_W-1:0] rd_re, rd_im;

   assign ready_in     = ~full[wr_bank];
   assign acc          = valid_in & ready_in;
   assign wr_done      = acc && (wr_idx == LAST_IDX);
   assign out_acc      = valid_out & ready_out;
   assign cp_start_cur = gi_f[rd_bank]  ? CPS_START : CPL_START;
   assign cp_start_oth = gi_f[~rd_bank] ? CPS_START : CPL_START;

   wifi_tx_cp_bank #(.SAMPLE_W(SAMPLE_W), .NFFT(NFFT), .IDX_W(IDX_W)) u_bank (
      .clk_ifft (clk_ifft),
      .we       (acc),
      .wr_sel   (wr_bank),
      .wr_idx   (wr_idx),
      .wr_re    (data_in_re),
      .wr_im    (data_in_im),
      .rd_sel   (rd_bank),
      .rd_idx   (rd_idx),
      .rd_re    (rd_re),
      .rd_im    (rd_im)
   );

   always_comb begin
      state_nxt  = state;
      rd_idx_nxt = rd_idx;
      issue      = 1'b0;
      body_end   = 1'b0;
      case (state)
         RD_IDLE: if (full[rd_bank]) begin
            state_nxt  = RD_CP;
            rd_idx_nxt = cp_start_cur;
         end
         RD_CP: if (!valid_out || ready_out) begin
            issue = 1'b1;
            if (rd_idx == LAST_IDX) begin
               state_nxt  = RD_BODY;
               rd_idx_nxt = '0;
            end else begin
               rd_idx_nxt = rd_idx + 1'b1;
            end
         end
         RD_BODY: if (!valid_out || ready_out) begin
            issue = 1'b1;
            if (rd_idx == LAST_IDX) begin
               body_end = 1'b1;
               // Chain straight into the next symbol's CP when it is already waiting.
               if (full[~rd_bank]) begin
                  state_nxt  = RD_CP;
                  rd_idx_nxt = cp_start_oth;
               end else begin
                  state_nxt  = RD_IDLE;
                  rd_idx_nxt = '0;
               end
            end else begin
               rd_idx_nxt = rd_idx + 1'b1;
            end
         end
         default: state_nxt = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk_ifft or negedge reset) begin
      if (!reset) begin
         state   <= RD_IDLE;
         rd_idx  <= '0;
         rd_bank <= 1'b0;
         wr_idx  <= '0;
         wr_bank <= 1'b0;
         full    <= '0;
         last_f  <= '0;
         gi_f    <= '0;
      end else begin
         state  <= state_nxt;
         rd_idx <= rd_idx_nxt;
         if (body_end) rd_bank <= ~rd_bank;
         if (acc) begin
            wr_idx <= wr_done ? '0 : wr_idx + 1'b1;
            if (wr_done) wr_bank <= ~wr_bank;
            if (wr_idx == '0) begin
               gi_f[wr_bank]   <= short_gi;
               last_f[wr_bank] <= last_sym_in;
            end else begin
               last_f[wr_bank] <= last_f[wr_bank] | last_sym_in;
            end
         end
         // Writer and reader always target different banks, so set and clear never collide.
         for (int b = 0; b < 2; b++) begin
            if (wr_done && (wr_bank == 1'(b)))       full[b] <= 1'b1;
            else if (body_end && (rd_bank == 1'(b))) full[b] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_ifft or negedge reset) begin
      if (!reset) begin
         valid_out     <= 1'b0;
         data_out_re   <= '0;
         data_out_im   <= '0;
         sym_start_out <= 1'b0;
         last_out      <= 1'b0;
         sym_end_q     <= 1'b0;
         sym_count     <= '0;
         frame_done    <= 1'b0;
         tx_irq        <= 1'b0;
      end else begin
         if (issue) begin
            valid_out     <= 1'b1;
            data_out_re   <= rd_re;
            data_out_im   <= rd_im;
            sym_start_out <= (state == RD_CP) && (rd_idx == cp_start_cur);
            last_out      <= body_end & last_f[rd_bank];
            sym_end_q     <= body_end;
         end else if (ready_out) begin
            valid_out     <= 1'b0;
            sym_start_out <= 1'b0;
            last_out      <= 1'b0;
            sym_end_q     <= 1'b0;
         end
         frame_done <= out_acc & last_out;
         if (out_acc && last_out)       sym_count <= '0;
         else if (out_acc && sym_end_q) sym_count <= sym_count + 16'd1;
         if (frame_done && en_tx_irq) tx_irq <= 1'b1;
         else if (clear_tx_irq)       tx_irq <= 1'b0;
      end
   end
endmodule

// File: tb/tb_wifi_tx_cp_framer.sv
// Scoreboard bench for wifi_tx_cp_framer: stimulus pushes expected framed samples,
// a negedge monitor pops and compares on every accepted output.
`timescale 1ns/1ps
module tb_wifi_tx_cp_framer;
   localparam int NF = 64;

   logic        clk_ifft = 1'b0;
   logic        reset = 1'b0;
   logic        valid_in = 1'b0, ready_in;
   logic [11:0] data_in_re = '0, data_in_im = '0;
   logic        last_sym_in = 1'b0, short_gi = 1'b0;
   logic        valid_out, ready_out;
   logic [11:0] data_out_re, data_out_im;
   logic        sym_start_out, last_out, frame_done, tx_irq;
   logic [15:0] sym_count;
   logic        en_tx_irq = 1'b0, clear_tx_irq = 1'b0;

   always #5 clk_ifft = ~clk_ifft;

   wifi_tx_cp_framer dut (
      .clk_ifft(clk_ifft), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
      .data_in_re(data_in_re), .data_in_im(data_in_im), .last_sym_in(last_sym_in),
      .short_gi(short_gi), .valid_out(valid_out), .ready_out(ready_out),
      .data_out_re(data_out_re), .data_out_im(data_out_im), .sym_start_out(sym_start_out),
      .last_out(last_out), .sym_count(sym_count), .en_tx_irq(en_tx_irq),
      .clear_tx_irq(clear_tx_irq), .tx_irq(tx_irq), .frame_done(frame_done)
   );

   typedef struct {
      logic [11:0] re;
      logic [11:0] im;
      logic        sos;
      logic        lst;
      logic        send;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_pass = 0;
   logic rnd_mode = 1'b0, saw_low = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Expected framed symbol: CP = last cp samples, then the whole body.
   task automatic push_sym(input int base, input logic gi, input logic lst);
      int cp = gi ? 8 : 16;
      for (int j = 0; j < cp + NF; j++) begin
         exp_t e;
         int idx = (j < cp) ? (NF - cp + j) : (j - cp);
         e.re   = 12'(base + idx);
         e.im   = -e.re;
         e.sos  = (j == 0);
         e.send = (j == cp + NF - 1);
         e.lst  = e.send & lst;
         q.push_back(e);
      end
   endtask

   task automatic send_sample(input int v, input logic gi, input logic lst);
      int t = 0;
      valid_in    = 1'b1;
      data_in_re  = 12'(v);
      data_in_im  = -12'(v);
      short_gi    = gi;
      last_sym_in = lst;
      forever begin
         @(negedge clk_ifft);
         if (ready_in) begin
            @(posedge clk_ifft);
            #1;
            break;
         end
         @(posedge clk_ifft);
         #1;
         if (++t > 5000) begin
            fail_now("send_ready_in");
            break;
         end
      end
   endtask

   task automatic send_sym(input int base, input logic gi, input logic lst);
      for (int k = 0; k < NF; k++) send_sample(base + k, gi, lst);
      valid_in = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((q.size() != 0 || valid_out) && t < 5000) begin
         @(posedge clk_ifft);
         #1;
         t++;
      end
      if (t >= 5000) fail_now("drain");
      repeat (4) @(posedge clk_ifft);
      #1;
   endtask

   initial begin
      ready_out = 1'b1;
      forever begin
         @(posedge clk_ifft);
         #1;
         ready_out = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk_ifft)
      if (reset && valid_in && !ready_in) saw_low <= 1'b1;

   // Monitor: expected sym_count / frame_done / tx_irq derive from the queue, not the DUT.
   logic [15:0] exp_sc = '0, nsc;
   logic        exp_fd = 1'b0, exp_irq = 1'b0, nfd, prev_stall = 1'b0;
   logic [25:0] prev_word = '0;
   exp_t        me;

   always @(negedge clk_ifft) begin
      if (!reset) begin
         exp_sc = '0; exp_fd = 1'b0; exp_irq = 1'b0; prev_stall = 1'b0;
      end else begin
         chk("sym_count", 32'(sym_count), 32'(exp_sc));
         chk("frame_done", 32'(frame_done), 32'(exp_fd));
         chk("tx_irq", 32'(tx_irq), 32'(exp_irq));
         if (prev_stall) begin
            chk("hold_valid", 32'(valid_out), 32'd1);
            chk("hold_data", 32'({data_out_re, data_out_im, sym_start_out, last_out}), 32'(prev_word));
         end
         nfd = 1'b0;
         nsc = exp_sc;
         if (valid_out && ready_out) begin
            if (q.size() == 0) begin
               chk("extra_output", 32'(valid_out), 32'd0);
            end else begin
               me = q.pop_front();
               chk("data_re", 32'(data_out_re), 32'(me.re));
               chk("data_im", 32'(data_out_im), 32'(me.im));
               chk("sym_start", 32'(sym_start_out), 32'(me.sos));
               chk("last_out", 32'(last_out), 32'(me.lst));
               if (me.lst) begin
                  nsc = '0;
                  nfd = 1'b1;
               end else if (me.send) begin
                  nsc = exp_sc + 16'd1;
               end
            end
         end
         exp_irq    = (exp_fd && en_tx_irq) ? 1'b1 : (clear_tx_irq ? 1'b0 : exp_irq);
         exp_fd     = nfd;
         exp_sc     = nsc;
         prev_stall = valid_out && !ready_out;
         prev_word  = {data_out_re, data_out_im, sym_start_out, last_out};
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      repeat (3) @(posedge clk_ifft);
      #1 reset = 1'b1;
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_ready_in", 32'(ready_in), 32'd1);
      chk("rst_sym_count", 32'(sym_count), 32'd0);
      chk("rst_tx_irq", 32'(tx_irq), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);

      // Single symbol, long GI, with output latency check.
      en_tx_irq = 1'b1;
      push_sym(0, 1'b0, 1'b1);
      send_sym(0, 1'b0, 1'b1);
      @(posedge clk_ifft); #1 chk("latency_1cyc", 32'(valid_out), 32'd0);
      @(posedge clk_ifft); #1 chk("latency_2cyc", 32'(valid_out), 32'd1);
      wait_drain();
      chk("t1_tx_irq", 32'(tx_irq), 32'd1);
      chk("t1_sym_count", 32'(sym_count), 32'd0);
      clear_tx_irq = 1'b1;
      @(posedge clk_ifft); #1 clear_tx_irq = 1'b0;
      chk("t1_irq_clear", 32'(tx_irq), 32'd0);

      // Three symbols back-to-back.
      saw_low = 1'b0;
      push_sym(0, 1'b0, 1'b0);
      push_sym(64, 1'b0, 1'b0);
      push_sym(128, 1'b0, 1'b1);
      for (int s = 0; s < 3; s++)
         for (int k = 0; k < NF; k++) send_sample(s * 64 + k, 1'b0, s == 2);
      valid_in = 1'b0;
      wait_drain();
      chk("t2_ready_in_dropped", 32'(saw_low), 32'd1);

      // Long GI then short GI.
      push_sym(0, 1'b0, 1'b0);
      push_sym(64, 1'b1, 1'b1);
      send_sym(0, 1'b0, 1'b0);
      send_sym(64, 1'b1, 1'b1);
      wait_drain();

      // Random downstream backpressure.
      rnd_mode = 1'b1;
      push_sym(0, 1'b0, 1'b1);
      send_sym(0, 1'b0, 1'b1);
      wait_drain();
      rnd_mode = 1'b0;
      repeat (2) @(posedge clk_ifft);
      #1;

      // Clear coinciding with frame_done: set wins; later clear drops it.
      clear_tx_irq = 1'b1;
      @(posedge clk_ifft); #1 clear_tx_irq = 1'b0;
      push_sym(0, 1'b0, 1'b1);
      send_sym(0, 1'b0, 1'b1);
      t = 0;
      while (!frame_done && t < 2000) begin
         @(posedge clk_ifft); #1;
         t++;
      end
      if (t >= 2000) fail_now("t5_frame_done");
      clear_tx_irq = 1'b1;
      @(posedge clk_ifft); #1 clear_tx_irq = 1'b0;
      chk("t5_set_wins", 32'(tx_irq), 32'd1);
      repeat (2) @(posedge clk_ifft);
      #1 clear_tx_irq = 1'b1;
      @(posedge clk_ifft); #1 clear_tx_irq = 1'b0;
      chk("t5_later_clear", 32'(tx_irq), 32'd0);
      wait_drain();
      en_tx_irq = 1'b0;
      push_sym(0, 1'b0, 1'b1);
      send_sym(0, 1'b0, 1'b1);
      wait_drain();
      chk("t5_irq_disabled", 32'(tx_irq), 32'd0);

      // Reset mid-symbol, then a fresh symbol.
      for (int k = 0; k < 30; k++) send_sample(500 + k, 1'b0, 1'b1);
      valid_in = 1'b0;
      reset = 1'b0;
      @(posedge clk_ifft); #1 reset = 1'b1;
      chk("t6_valid_out", 32'(valid_out), 32'd0);
      chk("t6_ready_in", 32'(ready_in), 32'd1);
      chk("t6_sym_count", 32'(sym_count), 32'd0);
      push_sym(0, 1'b0, 1'b1);
      send_sym(0, 1'b0, 1'b1);
      wait_drain();
      chk("t6_sym_count_end", 32'(sym_count), 32'd0);
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
